// File: rtl/program_memory_loader_pkg.sv
// ============================================================================
// Module : program_memory_loader_pkg
// Brief  : Loader FSM encodings, frame constants and word-address helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package program_memory_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam int          c_DEPTH_WORDS_DEFAULT = 128;
    localparam logic [7:0]  c_CHK_INIT            = 8'h00;

    // Byte address of word idx relative to base; always word aligned.
    function automatic logic [31:0] f_word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/program_memory_loader_byte_word_packer.sv
// ============================================================================
// Module : program_memory_loader_byte_word_packer
// Brief  : Packs four bytes into one raw word, first byte in [31:24].
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module program_memory_loader_byte_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_index,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_index;
    logic [23:0] r_acc;
    logic [31:0] r_word;
    logic        r_word_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_index      <= 2'd0;
            r_acc        <= 24'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_index <= 2'd0;
            end else if (i_byte_valid) begin
                r_acc   <= {r_acc[15:0], i_byte};
                r_index <= r_index + 2'd1;
                // Completed word is latched here so it holds until the next word completes.
                if (r_index == 2'd3) begin
                    r_word       <= {r_acc, i_byte};
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign o_index      = r_index;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule

`default_nettype wire

// File: rtl/program_memory_loader.sv
// ============================================================================
// Module : program_memory_loader
// Brief  : Receives a framed byte stream and writes raw words into program memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module program_memory_loader
    import program_memory_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = c_DEPTH_WORDS_DEFAULT,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    localparam logic [15:0] c_DEPTH = 16'(DEPTH_WORDS);

    state_t      r_state;
    logic [7:0]  r_len_lo;
    logic [15:0] r_len;
    logic [7:0]  r_chk;
    logic [15:0] r_words_written;
    logic [31:0] r_mem_addr;
    logic        r_done;
    logic        r_error;

    logic        w_accept_state;
    logic        w_rx_ready;
    logic        w_accept;
    logic        w_data_byte;
    logic [1:0]  w_byte_idx;
    logic        w_word_valid;
    logic [31:0] w_word;
    logic [15:0] w_len;

    assign w_accept_state = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                            (r_state == ST_DATA)   || (r_state == ST_CHECK);
    assign w_rx_ready     = w_accept_state && !start;
    assign w_accept       = rx_valid && w_rx_ready;
    assign w_data_byte    = w_accept && (r_state == ST_DATA);
    assign w_len          = {rx_data, r_len_lo};

    program_memory_loader_byte_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (start),
        .i_byte_valid (w_data_byte),
        .i_byte       (rx_data),
        .o_index      (w_byte_idx),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_len_lo        <= 8'd0;
            r_len           <= 16'd0;
            r_chk           <= c_CHK_INIT;
            r_words_written <= 16'd0;
            r_mem_addr      <= 32'd0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
        end else if (start) begin
            r_state         <= ST_LEN_LO;
            r_chk           <= c_CHK_INIT;
            r_words_written <= 16'd0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            case (r_state)
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len_lo <= rx_data;
                        r_state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        if (w_len == 16'd0) begin
                            r_state <= ST_CHECK;
                        end else if (w_len > c_DEPTH) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_chk <= r_chk ^ rx_data;
                        // Counter and address update now so they are visible with the write strobe.
                        if (w_byte_idx == 2'd3) begin
                            r_words_written <= r_words_written + 16'd1;
                            r_mem_addr      <= f_word_addr(BASE_ADDR, r_words_written);
                            if (r_words_written + 16'd1 == r_len) begin
                                r_state <= ST_CHECK;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_accept) begin
                        if (rx_data == r_chk) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign rx_ready      = w_rx_ready;
    assign mem_we        = w_word_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = w_word;
    assign busy          = w_accept_state || w_word_valid;
    assign done          = r_done;
    assign error         = r_error;
    assign words_written = r_words_written;

endmodule

`default_nettype wire
